approx_mult_pipe: RTL
=====================

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

Interface
REQ-001 Parameter W, default 8: operand width; SHALL be even and >= 4; H = W/2.
REQ-002 Parameter TRUNC, default 2: LSBs cleared in approximated partial products; SHALL be in 0..H.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  input transaction offered.
REQ-006 in_ready  out  1  block accepts input this cycle.
REQ-007 in_mode  in  1  0 = exact, 1 = approximate.
REQ-008 in_a, in_b  in  W each  unsigned operands.
REQ-009 out_valid  out  1  out_r holds a result.
REQ-010 out_ready  in  1  downstream accepts result.
REQ-011 out_r  out  2W  product.
REQ-012 out_mode  out  1  mode the result was computed with.

Function
REQ-013 Transfer on either port SHALL occur only on a cycle where valid and ready are both high.
REQ-014 Pipeline SHALL have 3 stages: S1 registers operands and mode; S2 registers four H x H partial products PLL=AL*BL, PLH=AL*BH, PHL=AH*BL, PHH=AH*BH; S3 registers the sum.
REQ-015 Latency SHALL be exactly 3 cycles from input acceptance to out_valid when not stalled; throughput 1 result per cycle.
REQ-016 Exact mode: out_r = (PHH<<W) + ((PLH+PHL)<<H) + PLL, equal to in_a*in_b.
REQ-017 Approximate mode: PLL, PLH and PHL SHALL each have their TRUNC LSBs forced to 0 before summation; PHH SHALL stay exact; sum formula as REQ-016.
REQ-018 TRUNC = 0 SHALL make approximate mode bit-identical to exact mode.
REQ-019 Mode SHALL be captured per transaction at acceptance and travel with its data; in_mode changes SHALL NOT affect in-flight results.
REQ-020 Stall = out_valid and not out_ready; during stall all stages SHALL hold data and valid bits unchanged.
REQ-021 in_ready SHALL equal not stall (combinational); at most 3 transactions in flight.
REQ-022 Bubbles (stage valid low) SHALL advance and collapse when not stalled; out_r and out_mode SHALL be held while out_valid is high and out_ready low.
REQ-023 Simultaneous output transfer and input acceptance in one cycle SHALL be allowed with no data loss.

Reset
REQ-024 On rst high, all stage valid bits, out_valid, out_r, out_mode and all data registers SHALL clear to 0 immediately, independent of clk.
REQ-025 in_ready SHALL be 1 while rst is high and after reset release; in-flight transactions at reset SHALL be discarded, none emitted.

Configuration
REQ-026 Macro APPROX_MULT_STATS_EN, when defined, SHALL add ports stat_clr (in, 1), stat_ops (out, 16), stat_approx (out, 16).
REQ-027 With macro: stat_ops SHALL increment per accepted input, stat_approx per accepted input with in_mode=1; both saturate at 0xFFFF; stat_clr high SHALL zero both synchronously, taking priority over increment; rst SHALL zero both.
REQ-028 Without macro: those ports and counters SHALL be absent; all other behaviour identical.

Verification (W=8, TRUNC=2)
REQ-029 Exact: a=0xFF, b=0xFF, mode 0, out_ready=1 -> out_valid 3 cycles later, out_r=65025, out_mode=0.
REQ-030 Approx: a=0xFF, b=0xFF, mode 1 -> out_r=64992; a=0x10, b=0x10, mode 1 -> out_r=256 (exact).
REQ-031 Stream 20 random pairs, alternating modes, out_ready=1 -> 20 results in order, 1 per cycle, each matching REQ-016/017 reference.
REQ-032 out_ready low 6 cycles with in_valid high -> exactly 3 accepted, in_ready low while stalled, out_r stable; on release results emerge in order, none lost or duplicated.
REQ-033 Assert rst with 2 in flight -> out_valid=0 at once, in_ready=1, no stale output after release.
REQ-034 With APPROX_MULT_STATS_EN: 5 accepts (3 approx) -> stat_ops=5, stat_approx=3; stat_clr concurrent with accept -> both 0.

Source files
------------

// File: rtl/approx_mult_pipe.sv
// rtl/approx_mult_pipe.sv - 3-stage exact/approximate unsigned multiplier (APPROX_MULT_STATS_EN adds op counters)
module approx_mult_pipe #(
   parameter int W     = 8,
   parameter int TRUNC = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           in_mode,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_r,
   output logic           out_mode
`ifdef APPROX_MULT_STATS_EN
   ,
   input  logic           stat_clr,
   output logic [15:0]    stat_ops,
   output logic [15:0]    stat_approx
`endif
);

   localparam int H = W / 2;
   localparam logic [W-1:0] MASK = ~W'((1 << TRUNC) - 1);

   logic           v1, m1;
   logic [W-1:0]   a1, b1;
   logic           v2, m2;
   logic [W-1:0]   pll, plh, phl, phh;
   logic           stall, accept;
   logic [W-1:0]   pll_c, plh_c, phl_c, phh_c;
   logic [2*W-1:0] sum;

   // A stalled output freezes the whole pipe, so bubbles only collapse while flowing.
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign accept   = in_valid & in_ready;

   always_comb begin
      pll_c = W'(a1[H-1:0]) * W'(b1[H-1:0]);
      plh_c = W'(a1[H-1:0]) * W'(b1[W-1:H]);
      phl_c = W'(a1[W-1:H]) * W'(b1[H-1:0]);
      phh_c = W'(a1[W-1:H]) * W'(b1[W-1:H]);
      if (m1) begin
         pll_c = pll_c & MASK;
         plh_c = plh_c & MASK;
         phl_c = phl_c & MASK;
      end
   end

   always_comb begin
      sum = ((2*W)'(phh) << W)
          + (((2*W)'(plh) + (2*W)'(phl)) << H)
          + (2*W)'(pll);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         m1        <= 1'b0;
         a1        <= '0;
         b1        <= '0;
         v2        <= 1'b0;
         m2        <= 1'b0;
         pll       <= '0;
         plh       <= '0;
         phl       <= '0;
         phh       <= '0;
         out_valid <= 1'b0;
         out_r     <= '0;
         out_mode  <= 1'b0;
      end else if (!stall) begin
         v1        <= in_valid;
         m1        <= in_mode;
         a1        <= in_a;
         b1        <= in_b;
         v2        <= v1;
         m2        <= m1;
         pll       <= pll_c;
         plh       <= plh_c;
         phl       <= phl_c;
         phh       <= phh_c;
         out_valid <= v2;
         out_r     <= sum;
         out_mode  <= m2;
      end
   end

`ifdef APPROX_MULT_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_ops    <= '0;
         stat_approx <= '0;
      end else if (stat_clr) begin
         stat_ops    <= '0;
         stat_approx <= '0;
      end else if (accept) begin
         if (stat_ops != 16'hFFFF)
            stat_ops <= stat_ops + 16'd1;
         if (in_mode && stat_approx != 16'hFFFF)
            stat_approx <= stat_approx + 16'd1;
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule
